// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register-file backend.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } chan_state_t;

  localparam logic [7:0]  ID           = 8'd0;
  localparam logic [7:0]  STATUS       = 8'd1;
  localparam logic [7:0]  CYCLES       = 8'd2;
  localparam logic [7:0]  SCRATCH_BASE = 8'd3;
  localparam logic [31:0] ID_VALUE     = 32'hA41E_0001;

  // Word-aligned, inside the 1 KiB window and below the register count.
  function automatic logic addr_in_map(input logic [31:0] addr, input int unsigned num_regs);
    return (addr[1:0] == 2'b00) && (addr[31:10] == 22'd0) &&
           ({24'd0, addr[9:2]} < num_regs);
  endfunction

endpackage

// File: rtl/axi4_lite_chan_fsm.sv
// One request channel: IDLE -> WAIT -> DONE sequencing, request latching,
// done pulse and drop indication for requests arriving while busy.
module axi4_lite_chan_fsm
  import axi4_lite_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned PW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [PW-1:0] i_payload,
  output logic [PW-1:0] o_payload,
  output logic          o_commit,
  output logic          o_done,
  output logic          o_drop
);

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = 4'(NO_WAIT ? 0 : WAIT_CYCLES - 1);

  chan_state_t   r_state;
  logic [3:0]    r_cnt;
  logic [PW-1:0] r_payload;

  // With no wait states the request commits on its own sampling edge, so the
  // live inputs must be presented instead of the not-yet-latched copy.
  assign o_payload = (r_state == IDLE) ? i_payload : r_payload;
  assign o_commit  = rst_n && (((r_state == IDLE) && i_req && NO_WAIT) ||
                               ((r_state == WAIT) && (r_cnt == 4'd0)));
  assign o_drop    = rst_n && i_req && (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_payload <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_payload <= i_payload;
            r_cnt     <= CNT_INIT;
            if (NO_WAIT) begin
              r_state <= DONE;
              o_done  <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            o_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// Register-file backend behind axi4_lite_slave: ID, sticky STATUS, free-running
// CYCLES counter and byte-writable scratch registers with independent channels.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_waddr,
  input  logic [31:0] slave_wdata,
  input  logic [3:0]  slave_wstrb,
  input  logic        send_slave_write,
  input  logic [31:0] slave_raddr,
  input  logic        send_slave_read,
  output logic [31:0] slave_rdata,
  output logic        slave_write_done,
  output logic        slave_read_done,
  output logic [1:0]  slave_bresp,
  output logic [1:0]  slave_rresp
);

  localparam int unsigned IW = $clog2(NUM_REGS);

  logic [67:0] w_wpay;
  logic [31:0] w_waddr, w_wdata, w_raddr, w_rdval;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_widx, w_ridx;
  logic        w_wcommit, w_rcommit, w_wdrop, w_rdrop, w_werr, w_rerr;
  logic [1:0]  w_clr;

  logic [31:0] r_cycles;
  logic [1:0]  r_status;
  logic [31:0] r_scratch [NUM_REGS];
  logic [31:0] r_rdata;
  resp_t       r_bresp, r_rresp;

  axi4_lite_chan_fsm #(.WAIT_CYCLES(WAIT_CYCLES), .PW(68)) u_wchan (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (send_slave_write),
    .i_payload ({slave_waddr, slave_wdata, slave_wstrb}),
    .o_payload (w_wpay),
    .o_commit  (w_wcommit),
    .o_done    (slave_write_done),
    .o_drop    (w_wdrop)
  );

  axi4_lite_chan_fsm #(.WAIT_CYCLES(WAIT_CYCLES), .PW(32)) u_rchan (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (send_slave_read),
    .i_payload (slave_raddr),
    .o_payload (w_raddr),
    .o_commit  (w_rcommit),
    .o_done    (slave_read_done),
    .o_drop    (w_rdrop)
  );

  assign w_waddr = w_wpay[67:36];
  assign w_wdata = w_wpay[35:4];
  assign w_wstrb = w_wpay[3:0];
  assign w_widx  = w_waddr[9:2];
  assign w_ridx  = w_raddr[9:2];

  assign w_werr = !addr_in_map(w_waddr, NUM_REGS) || (w_widx == ID) || (w_widx == CYCLES);
  assign w_rerr = !addr_in_map(w_raddr, NUM_REGS);

  assign w_clr = (w_wcommit && !w_werr && (w_widx == STATUS) && w_wstrb[0]) ?
                 w_wdata[1:0] : 2'b00;

  always_comb begin
    w_rdval = 32'd0;
    if (!w_rerr) begin
      case (w_ridx)
        ID:      w_rdval = ID_VALUE;
        STATUS:  w_rdval = {30'd0, r_status};
        CYCLES:  w_rdval = r_cycles;
        default: w_rdval = r_scratch[w_ridx[IW-1:0]];
      endcase
    end
  end

  // Drop flags are OR-ed in after the clear so a same-edge set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycles  <= 32'd0;
      r_status  <= 2'b00;
      r_scratch <= '{default: '0};
    end else begin
      r_cycles <= r_cycles + 32'd1;
      r_status <= (r_status & ~w_clr) | {w_rdrop, w_wdrop};
      if (w_wcommit && !w_werr && (w_widx != STATUS)) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wstrb[b]) r_scratch[w_widx[IW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_bresp <= OKAY;
      r_rresp <= OKAY;
    end else begin
      if (w_wcommit) r_bresp <= w_werr ? SLVERR : OKAY;
      if (w_rcommit) begin
        r_rresp <= w_rerr ? SLVERR : OKAY;
        r_rdata <= w_rdval;
      end
    end
  end

  assign slave_rdata = r_rdata;
  assign slave_bresp = r_bresp;
  assign slave_rresp = r_rresp;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Testbench for axi4_lite_regfile: one instance with no wait states, one with
// three, driven by a vector table, random traffic and multi-cycle sequences.
module tb_axi4_lite_regfile;

  localparam int unsigned NUM_REGS = 16;
  localparam logic [1:0]  R_OKAY   = 2'b00;
  localparam logic [1:0]  R_SLVERR = 2'b10;

  logic        clk;
  logic        rstN   [2];
  logic [31:0] waddr  [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wreq   [2];
  logic [31:0] raddr  [2];
  logic        rreq   [2];
  logic [31:0] rdata  [2];
  logic        wdone  [2];
  logic        rdone  [2];
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];

  int checks   = 0;
  int errors   = 0;
  int cycCount = 0;

  logic [31:0] mMem [NUM_REGS];
  logic [1:0]  mStat;

  axi4_lite_regfile #(.NUM_REGS(NUM_REGS), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rstN[0]),
    .slave_waddr(waddr[0]), .slave_wdata(wdata[0]), .slave_wstrb(wstrb[0]),
    .send_slave_write(wreq[0]), .slave_raddr(raddr[0]), .send_slave_read(rreq[0]),
    .slave_rdata(rdata[0]), .slave_write_done(wdone[0]), .slave_read_done(rdone[0]),
    .slave_bresp(bresp[0]), .slave_rresp(rresp[0])
  );

  axi4_lite_regfile #(.NUM_REGS(NUM_REGS), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rstN[1]),
    .slave_waddr(waddr[1]), .slave_wdata(wdata[1]), .slave_wstrb(wstrb[1]),
    .send_slave_write(wreq[1]), .slave_raddr(raddr[1]), .send_slave_read(rreq[1]),
    .slave_rdata(rdata[1]), .slave_write_done(wdone[1]), .slave_read_done(rdone[1]),
    .slave_bresp(bresp[1]), .slave_rresp(rresp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycCount <= cycCount + 1;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  expResp;
    logic [31:0] expData;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request at a negedge and waits (bounded) for its done pulse.
  task automatic applyStimulus(input int d, input bit isWrite, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [31:0] rd,
                               output int lat, output int t);
    @(negedge clk);
    if (isWrite) begin
      waddr[d] = addr; wdata[d] = data; wstrb[d] = strb; wreq[d] = 1'b1;
    end else begin
      raddr[d] = addr; rreq[d] = 1'b1;
    end
    t = cycCount; lat = 0; resp = 2'b11; rd = 32'hxxxx_xxxx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      wreq[d] = 1'b0; rreq[d] = 1'b0;
      if (isWrite ? wdone[d] : rdone[d]) begin
        lat = c;
        resp = isWrite ? bresp[d] : rresp[d];
        rd = rdata[d];
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("[TB] FAIL timeout dut%0d addr 0x%08h: no done within 20 cycles", d, addr);
    end
  endtask

  // Reference model of the no-wait instance, written from the register map rules.
  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    int idx;
    bit bad;
    idx = int'(addr / 4);
    bad = (addr % 4 != 0) || (addr >= 1024) || (idx >= int'(NUM_REGS));
    if (bad || idx == 0 || idx == 2) begin
      resp = R_SLVERR;
    end else begin
      resp = R_OKAY;
      if (idx == 1) begin
        if (strb[0]) mStat = mStat & ~data[1:0];
      end else begin
        for (int b = 0; b < 4; b++) if (strb[b]) mMem[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic modelRead(input logic [31:0] addr, output logic [1:0] resp, output logic [31:0] val);
    int idx;
    idx = int'(addr / 4);
    if ((addr % 4 != 0) || (addr >= 1024) || (idx >= int'(NUM_REGS))) begin
      resp = R_SLVERR; val = 32'd0;
    end else begin
      resp = R_OKAY;
      if (idx == 0)      val = 32'hA41E_0001;
      else if (idx == 1) val = {30'd0, mStat};
      else               val = mMem[idx];
    end
  endtask

  initial begin
    vec_t        vecs [18];
    logic [1:0]  resp, expResp, bResp;
    logic [31:0] rd, expData, v1, v2, addr, data;
    logic [3:0]  strb;
    int          lat, t, t1, t2, firstDone, nDone, rGot, wGot, idx;
    bit          isWr;

    vecs[0]  = '{1, 32'h00C, 32'hDEADBEEF, 4'hF, R_OKAY,   32'h0};
    vecs[1]  = '{0, 32'h00C, 32'h0,        4'h0, R_OKAY,   32'hDEADBEEF};
    vecs[2]  = '{1, 32'h00C, 32'h11223344, 4'h5, R_OKAY,   32'h0};
    vecs[3]  = '{0, 32'h00C, 32'h0,        4'h0, R_OKAY,   32'hDE22BE44};
    vecs[4]  = '{1, 32'h000, 32'h12345678, 4'hF, R_SLVERR, 32'h0};
    vecs[5]  = '{0, 32'h000, 32'h0,        4'h0, R_OKAY,   32'hA41E0001};
    vecs[6]  = '{0, 32'h002, 32'h0,        4'h0, R_SLVERR, 32'h0};
    vecs[7]  = '{0, 32'h040, 32'h0,        4'h0, R_SLVERR, 32'h0};
    vecs[8]  = '{1, 32'h400, 32'hCAFEF00D, 4'hF, R_SLVERR, 32'h0};
    vecs[9]  = '{0, 32'h400, 32'h0,        4'h0, R_SLVERR, 32'h0};
    vecs[10] = '{1, 32'h008, 32'h0,        4'hF, R_SLVERR, 32'h0};
    vecs[11] = '{1, 32'h010, 32'hFFFFFFFF, 4'h0, R_OKAY,   32'h0};
    vecs[12] = '{0, 32'h010, 32'h0,        4'h0, R_OKAY,   32'h0};
    vecs[13] = '{0, 32'h004, 32'h0,        4'h0, R_OKAY,   32'h0};
    vecs[14] = '{1, 32'h03C, 32'h0BADF00D, 4'h3, R_OKAY,   32'h0};
    vecs[15] = '{0, 32'h03C, 32'h0,        4'h0, R_OKAY,   32'h0000F00D};
    vecs[16] = '{1, 32'h00E, 32'h99999999, 4'hF, R_SLVERR, 32'h0};
    vecs[17] = '{0, 32'h00C, 32'h0,        4'h0, R_OKAY,   32'hDE22BE44};

    for (int i = 0; i < int'(NUM_REGS); i++) mMem[i] = 32'd0;
    mStat = 2'b00;
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0; waddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      wreq[d] = 1'b0; raddr[d] = '0; rreq[d] = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst%0d_rdata", d), rdata[d], 32'd0);
      checkOutput($sformatf("rst%0d_wdone", d), {31'd0, wdone[d]}, 32'd0);
      checkOutput($sformatf("rst%0d_rdone", d), {31'd0, rdone[d]}, 32'd0);
      checkOutput($sformatf("rst%0d_bresp", d), {30'd0, bresp[d]}, 32'd0);
      checkOutput($sformatf("rst%0d_rresp", d), {30'd0, rresp[d]}, 32'd0);
    end
    rstN[0] = 1'b1; rstN[1] = 1'b1;

    $display("[TB] identity, status and cycle counter after reset");
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("id_data", rd, 32'hA41E_0001);
    checkOutput("id_resp", {30'd0, resp}, {30'd0, R_OKAY});
    applyStimulus(0, 0, 32'h4, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("status_reset", rd, 32'd0);
    applyStimulus(0, 0, 32'h8, 32'h0, 4'h0, resp, v1, lat, t1);
    checkOutput("cycles_resp", {30'd0, resp}, {30'd0, R_OKAY});
    checkOutput("cycles_small", {31'd0, v1 < 32'd32}, 32'd1);
    repeat (10) @(negedge clk);
    applyStimulus(0, 0, 32'h8, 32'h0, 4'h0, resp, v2, lat, t2);
    checkOutput("cycles_delta", v2 - v1, 32'(t2 - t1));

    $display("[TB] vector table, no wait states");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, vecs[i].isWrite, vecs[i].addr, vecs[i].data, vecs[i].strb, resp, rd, lat, t);
      if (vecs[i].isWrite) modelWrite(vecs[i].addr, vecs[i].data, vecs[i].strb, expResp);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      checkOutput($sformatf("vec%0d_resp", i), {30'd0, resp}, {30'd0, vecs[i].expResp});
      if (!vecs[i].isWrite) checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].expData);
    end

    $display("[TB] random traffic against reference model");
    for (int i = 0; i < 80; i++) begin
      isWr = 1'($urandom_range(0, 1));
      idx  = int'($urandom_range(0, NUM_REGS + 1));
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'(idx * 4) | 32'($urandom_range(1, 3));
        default: addr = 32'(idx * 4);
      endcase
      if (!isWr && addr == 32'h8) addr = 32'hC;
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      applyStimulus(0, isWr, addr, data, strb, resp, rd, lat, t);
      if (isWr) begin
        modelWrite(addr, data, strb, expResp);
      end else begin
        modelRead(addr, expResp, expData);
        checkOutput($sformatf("rand%0d_data", i), rd, expData);
      end
      checkOutput($sformatf("rand%0d_resp", i), {30'd0, resp}, {30'd0, expResp});
    end

    $display("[TB] three wait states: latency and dropped write");
    @(negedge clk);
    waddr[1] = 32'h0C; wdata[1] = 32'h600DCAFE; wstrb[1] = 4'hF; wreq[1] = 1'b1;
    firstDone = 0; nDone = 0; bResp = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin waddr[1] = 32'h10; wdata[1] = 32'h0BADBAD0; end
      if (c == 2) wreq[1] = 1'b0;
      if (wdone[1]) begin
        nDone++;
        if (firstDone == 0) begin firstDone = c; bResp = bresp[1]; end
      end
    end
    checkOutput("w3_latency", 32'(firstDone), 32'd4);
    checkOutput("w3_done_count", 32'(nDone), 32'd1);
    checkOutput("w3_bresp", {30'd0, bResp}, {30'd0, R_OKAY});
    applyStimulus(1, 0, 32'h4, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("w3_status_drop", rd, 32'h1);
    checkOutput("w3_read_lat", 32'(lat), 32'd4);
    applyStimulus(1, 0, 32'hC, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("w3_kept_write", rd, 32'h600DCAFE);
    applyStimulus(1, 0, 32'h10, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("w3_dropped_target", rd, 32'h0);
    applyStimulus(1, 1, 32'h4, 32'h1, 4'h1, resp, rd, lat, t);
    checkOutput("w3_w1c_resp", {30'd0, resp}, {30'd0, R_OKAY});
    applyStimulus(1, 0, 32'h4, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("w3_status_cleared", rd, 32'h0);

    $display("[TB] same-cycle read and write of one register");
    applyStimulus(1, 1, 32'h10, 32'hAAAA_AAAA, 4'hF, resp, rd, lat, t);
    @(negedge clk);
    waddr[1] = 32'h10; wdata[1] = 32'h5555_5555; wstrb[1] = 4'hF; wreq[1] = 1'b1;
    raddr[1] = 32'h10; rreq[1] = 1'b1;
    rGot = 0; wGot = 0; v1 = 32'hxxxx_xxxx;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      wreq[1] = 1'b0; rreq[1] = 1'b0;
      if (rdone[1] && rGot == 0) begin rGot = c; v1 = rdata[1]; end
      if (wdone[1] && wGot == 0) wGot = c;
    end
    checkOutput("same_rlat", 32'(rGot), 32'd4);
    checkOutput("same_wlat", 32'(wGot), 32'd4);
    checkOutput("same_old_value", v1, 32'hAAAA_AAAA);
    applyStimulus(1, 0, 32'h10, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("same_new_value", rd, 32'h5555_5555);

    $display("[TB] reset during a waiting write");
    @(negedge clk);
    waddr[1] = 32'h14; wdata[1] = 32'h1234_5678; wstrb[1] = 4'hF; wreq[1] = 1'b1;
    nDone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) waddr[1] = 32'h18;
      if (c == 2) begin wreq[1] = 1'b0; rstN[1] = 1'b0; end
      if (c == 3) rstN[1] = 1'b1;
      if (wdone[1]) nDone++;
    end
    checkOutput("rstmid_no_done", 32'(nDone), 32'd0);
    applyStimulus(1, 0, 32'h14, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("rstmid_target", rd, 32'h0);
    applyStimulus(1, 0, 32'h4, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("rstmid_status", rd, 32'h0);
    applyStimulus(1, 0, 32'hC, 32'h0, 4'h0, resp, rd, lat, t);
    checkOutput("rstmid_scratch", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Register-file backend directly downstream of `axi4_lite_slave`: it consumes the slave's decoded write/read requests (`slave_waddr`/`slave_wdata`/`slave_wstrb`/`send_slave_write`, `slave_raddr`/`send_slave_read`) and returns completion pulses, read data and responses. It provides an ID register, a sticky status register, a free-running cycle counter and a bank of byte-writable scratch registers. Each channel has a configurable number of wait states.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers; legal range 4..256.
- `WAIT_CYCLES`, 0: extra wait states per transaction, per channel; legal range 0..15.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `slave_waddr` in 32: write byte address.
- `slave_wdata` in 32: write data.
- `slave_wstrb` in 4: byte enables; bit i covers `wdata[8i+7:8i]`.
- `send_slave_write` in 1: one-cycle write request pulse.
- `slave_raddr` in 32: read byte address.
- `send_slave_read` in 1: one-cycle read request pulse.
- `slave_rdata` out 32: read data, valid while `slave_read_done`=1.
- `slave_write_done` out 1: one-cycle write completion pulse.
- `slave_read_done` out 1: one-cycle read completion pulse.
- `slave_bresp` out 2: write response, valid with `slave_write_done`.
- `slave_rresp` out 2: read response, valid with `slave_read_done`.

## Operation
- Register map (index = `addr[9:2]`):
  - 0 ID: RO, 0xA41E_0001.
  - 1 STATUS: bit0 = write dropped, bit1 = read dropped; sticky. Write-1-to-clear through the strobe of byte 0. Other bits read 0.
  - 2 CYCLES: RO 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
  - 3..NUM_REGS-1 SCRATCH: RW with byte strobes.
- Error conditions, all responding SLVERR (2'b10) with no state change:
  - `addr[1:0]`≠0.
  - `addr[31:10]`≠0.
  - index ≥ NUM_REGS.
  - Write to ID or CYCLES.
- Failed reads return `rdata`=0 with SLVERR. All other transactions respond OKAY (2'b00).
- The write and read channels are independent FSMs, each with states IDLE → WAIT → DONE → IDLE:
  - IDLE→WAIT when a request is sampled; the address, data and strobe are latched. If WAIT_CYCLES=0, IDLE→DONE directly.
  - WAIT counts WAIT_CYCLES cycles, then moves to DONE.
  - DONE drives the done pulse for one cycle, then returns to IDLE.
- A request sampled while its channel is not IDLE is dropped: no response, and the matching STATUS bit is set.
- A write with `wstrb`=0 to a legal address responds OKAY and changes nothing.

## Timing
- Request sampled at the edge ending cycle N → done pulse in cycle N+1+WAIT_CYCLES.
- Maximum throughput per channel is one transaction per 2+WAIT_CYCLES cycles.
- A write commits on the edge that enters DONE, so the new value is readable by any read sampled from the cycle of the done pulse onward.
- Read data is captured on the edge that enters DONE.
- Read and write entering DONE in the same cycle on the same register: the read returns the pre-write value.
- CYCLES read returns the counter value at the capture edge.
- Drop-flag set and W1C clear of the same bit on the same edge: set wins.
- Reset values:
  - All outputs 0; `slave_bresp`/`slave_rresp` = OKAY.
  - FSMs IDLE; STATUS 0; CYCLES 0; SCRATCH 0.
- Reset asserted mid-transaction: pending transactions are discarded with no done pulse. Requests sampled while `rst_n`=0 are ignored.

## Structure
- `axi4_lite_pkg` holds:
  - `resp_t` enum: OKAY=2'b00, SLVERR=2'b10.
  - Register index localparams: ID=0, STATUS=1, CYCLES=2, SCRATCH_BASE=3.
  - ID value constant.
  - `chan_state_t` enum: IDLE, WAIT, DONE.
- One sub-module, `axi4_lite_chan_fsm`, instanced once for writes and once for reads. It holds the FSM, the wait counter, request latching, the done pulse and the drop indication. The top level holds decode, storage and response muxing.

## Test plan
- Reset, then read 0x0, 0x4 and 0x8 → 0xA41E_0001 / 0 / small CYCLES value, all OKAY. A second CYCLES read 10 cycles later is larger by 10 plus the spacing between the two read requests.
- WAIT_CYCLES=0:
  - Write 0x0C with data 0xDEADBEEF, `wstrb`=0xF → `write_done` in cycle N+1, OKAY.
  - Read 0x0C → 0xDEADBEEF.
  - Write 0x0C with data 0x11223344, `wstrb`=0x5 → reads 0xDE22BE44.
- Errors:
  - Write 0x0 → SLVERR, ID unchanged.
  - Read 0x2 → SLVERR, `rdata`=0.
  - Read 4×NUM_REGS → SLVERR.
  - Write 0x400 → SLVERR.
- WAIT_CYCLES=3:
  - Write request at cycle N → done at N+4.
  - A second write at N+1 is dropped and STATUS reads 0x1.
  - Write 0x1 to 0x4 → STATUS reads 0.
- Same-cycle read and write of 0x10 (old value 0xAAAA_AAAA, new value 0x5555_5555) → read returns 0xAAAA_AAAA; a following read returns 0x5555_5555.
- `rst_n` low for one cycle while a WAIT_CYCLES=3 write is in WAIT → no `write_done`; the target reads 0 and STATUS reads 0 after reset.
